// File: rtl/pcie_rx_pkg.sv
// Shared receive-side framing definitions: token encodings, sync headers,
// parser states and the per-byte marker bundle.
package pcie_rx_pkg;

    localparam logic [3:0] STP_NIB   = 4'hF;
    localparam logic [7:0] SDP_TOK   = 8'hF0;
    localparam logic [7:0] EDB_TOK   = 8'hC0;
    localparam logic [7:0] IDL_TOK   = 8'h00;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

    localparam int MIN_TLP_DW = 5;
    localparam int LEN_W      = 11;
    localparam int SDP_CNT    = 7;
    localparam int EDB_CNT    = 3;

    typedef enum logic [2:0] {
        ST_TOKEN = 3'd0,
        ST_STP1  = 3'd1,
        ST_TLP   = 3'd2,
        ST_SDP   = 3'd3,
        ST_EDB   = 3'd4,
        ST_ERR   = 3'd5
    } fr_state_e;

    typedef struct packed {
        logic valid;
        logic tlpstart;
        logic tlpend;
        logic tlpedb;
        logic dlpstart;
        logic dlpend;
    } fr_mark_t;

    // True while a packet is partially received; an ordered-set block here is a violation.
    function automatic logic is_mid_packet(input fr_state_e s);
        return (s == ST_STP1) || (s == ST_TLP) || (s == ST_SDP) || (s == ST_EDB);
    endfunction

endpackage

// File: rtl/framing_byte_step.sv
// One byte of the framing walk: given the context before this byte, produce
// the context after it, the byte's markers and a violation flag.
module framing_byte_step
    import pcie_rx_pkg::*;
#(
    parameter int CNT_W = 13
) (
    input  fr_state_e        state_in,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [7:0]       byte_in,
    output fr_state_e        state_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic [LEN_W-1:0] len_out,
    output fr_mark_t         mark,
    output logic             err
);

    logic [LEN_W-1:0] stp_len_s;
    logic             cnt_last_s;

    assign stp_len_s  = {byte_in[6:0], len_in[3:0]};
    assign cnt_last_s = (cnt_in <= CNT_W'(1));

    // Token decode and countdown for a single byte
    always_comb begin
        state_out = state_in;
        cnt_out   = cnt_in;
        len_out   = len_in;
        mark      = '0;
        err       = 1'b0;
        case (state_in)
            ST_TOKEN: begin
                if (byte_in[3:0] == STP_NIB) begin
                    len_out       = {{(LEN_W-4){1'b0}}, byte_in[7:4]};
                    state_out     = ST_STP1;
                    mark.valid    = 1'b1;
                    mark.tlpstart = 1'b1;
                end else if (byte_in == SDP_TOK) begin
                    cnt_out       = CNT_W'(SDP_CNT);
                    state_out     = ST_SDP;
                    mark.valid    = 1'b1;
                    mark.dlpstart = 1'b1;
                end else if (byte_in == EDB_TOK) begin
                    cnt_out     = CNT_W'(EDB_CNT);
                    state_out   = ST_EDB;
                    mark.valid  = 1'b1;
                    mark.tlpedb = 1'b1;
                end else if (byte_in == IDL_TOK) begin
                    state_out = ST_TOKEN;
                end else begin
                    err       = 1'b1;
                    state_out = ST_ERR;
                    cnt_out   = '0;
                end
            end
            ST_STP1: begin
                len_out = stp_len_s;
                if (stp_len_s < LEN_W'(MIN_TLP_DW)) begin
                    err       = 1'b1;
                    state_out = ST_ERR;
                    cnt_out   = '0;
                end else begin
                    // Both STP bytes are already consumed, hence the -2.
                    cnt_out    = CNT_W'({stp_len_s, 2'b00}) - CNT_W'(2);
                    state_out  = ST_TLP;
                    mark.valid = 1'b1;
                end
            end
            ST_TLP: begin
                mark.valid = 1'b1;
                if (cnt_last_s) begin
                    mark.tlpend = 1'b1;
                    state_out   = ST_TOKEN;
                    cnt_out     = '0;
                end else begin
                    cnt_out = cnt_in - CNT_W'(1);
                end
            end
            ST_SDP: begin
                mark.valid = 1'b1;
                if (cnt_last_s) begin
                    mark.dlpend = 1'b1;
                    state_out   = ST_TOKEN;
                    cnt_out     = '0;
                end else begin
                    cnt_out = cnt_in - CNT_W'(1);
                end
            end
            ST_EDB: begin
                if (byte_in == EDB_TOK) begin
                    mark.valid  = 1'b1;
                    mark.tlpedb = 1'b1;
                    if (cnt_last_s) begin
                        state_out = ST_TOKEN;
                        cnt_out   = '0;
                    end else begin
                        cnt_out = cnt_in - CNT_W'(1);
                    end
                end else begin
                    err       = 1'b1;
                    state_out = ST_ERR;
                    cnt_out   = '0;
                end
            end
            ST_ERR: begin
                state_out = ST_ERR;
            end
            default: begin
                err       = 1'b1;
                state_out = ST_ERR;
                cnt_out   = '0;
            end
        endcase
    end

endmodule

// File: rtl/gen3_framing_parser.sv
// 128b/130b receive framing parser: chains one byte step per active lane and
// registers the resulting context, per-byte markers and error pulse.
module gen3_framing_parser
    import pcie_rx_pkg::*;
#(
    parameter int LANES = 16,
    parameter int CNT_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*LANES-1:0] data_in,
    input  logic               valid_in,
    input  logic               block_start,
    input  logic [1:0]         sync_hdr,
    input  logic [4:0]         active_lanes,
    output logic [8*LANES-1:0] data_out,
    output logic [LANES-1:0]   pl_valid,
    output logic [LANES-1:0]   pl_tlpstart,
    output logic [LANES-1:0]   pl_tlpend,
    output logic [LANES-1:0]   pl_tlpedb,
    output logic [LANES-1:0]   pl_dlpstart,
    output logic [LANES-1:0]   pl_dlpend,
    output logic               framing_err
);

    fr_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [LEN_W-1:0] len_r;
    logic             os_blk_r;

    logic             data_blk_s;
    logic             os_start_s;
    logic             in_os_s;
    logic             os_abort_s;
    fr_state_e        seed_state_s;
    logic [CNT_W-1:0] seed_cnt_s;
    logic [LEN_W-1:0] seed_len_s;

    logic [LANES-1:0] lane_en_s;
    logic [LANES-1:0] err_s;
    logic [LANES-1:0] nx_valid_s;
    logic [LANES-1:0] nx_tlpstart_s;
    logic [LANES-1:0] nx_tlpend_s;
    logic [LANES-1:0] nx_tlpedb_s;
    logic [LANES-1:0] nx_dlpstart_s;
    logic [LANES-1:0] nx_dlpend_s;

    // Block-level qualification and the context fed into byte 0
    always_comb begin
        data_blk_s = valid_in && block_start && (sync_hdr == SYNC_DATA);
        os_start_s = valid_in && block_start && (sync_hdr != SYNC_DATA);
        in_os_s    = os_start_s || (valid_in && !block_start && os_blk_r);
        os_abort_s = os_start_s && is_mid_packet(state_r);
        if (data_blk_s && (state_r == ST_ERR)) begin
            seed_state_s = ST_TOKEN;
            seed_cnt_s   = '0;
            seed_len_s   = '0;
        end else begin
            seed_state_s = state_r;
            seed_cnt_s   = cnt_r;
            seed_len_s   = len_r;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fr_state_e        st_in_s;
        logic [CNT_W-1:0] cnt_in_s;
        logic [LEN_W-1:0] len_in_s;
        fr_state_e        step_state_s;
        logic [CNT_W-1:0] step_cnt_s;
        logic [LEN_W-1:0] step_len_s;
        fr_mark_t         step_mark_s;
        logic             step_err_s;
        fr_state_e        st_out_s;
        logic [CNT_W-1:0] cnt_out_s;
        logic [LEN_W-1:0] len_out_s;

        if (i == 0) begin : g_first
            assign st_in_s  = seed_state_s;
            assign cnt_in_s = seed_cnt_s;
            assign len_in_s = seed_len_s;
        end else begin : g_next
            assign st_in_s  = g_lane[i-1].st_out_s;
            assign cnt_in_s = g_lane[i-1].cnt_out_s;
            assign len_in_s = g_lane[i-1].len_out_s;
        end

        framing_byte_step #(
            .CNT_W (CNT_W)
        ) u_step (
            .state_in  (st_in_s),
            .cnt_in    (cnt_in_s),
            .len_in    (len_in_s),
            .byte_in   (data_in[8*i +: 8]),
            .state_out (step_state_s),
            .cnt_out   (step_cnt_s),
            .len_out   (step_len_s),
            .mark      (step_mark_s),
            .err       (step_err_s)
        );

        // Lanes above the configured width pass the context through untouched.
        assign lane_en_s[i]     = (active_lanes > 5'(i));
        assign st_out_s         = lane_en_s[i] ? step_state_s : st_in_s;
        assign cnt_out_s        = lane_en_s[i] ? step_cnt_s : cnt_in_s;
        assign len_out_s        = lane_en_s[i] ? step_len_s : len_in_s;
        assign err_s[i]         = lane_en_s[i] & step_err_s;
        assign nx_valid_s[i]    = lane_en_s[i] & step_mark_s.valid;
        assign nx_tlpstart_s[i] = lane_en_s[i] & step_mark_s.tlpstart;
        assign nx_tlpend_s[i]   = lane_en_s[i] & step_mark_s.tlpend;
        assign nx_tlpedb_s[i]   = lane_en_s[i] & step_mark_s.tlpedb;
        assign nx_dlpstart_s[i] = lane_en_s[i] & step_mark_s.dlpstart;
        assign nx_dlpend_s[i]   = lane_en_s[i] & step_mark_s.dlpend;
    end

    // Parser context and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_TOKEN;
            cnt_r       <= '0;
            len_r       <= '0;
            os_blk_r    <= 1'b0;
            data_out    <= '0;
            pl_valid    <= '0;
            pl_tlpstart <= '0;
            pl_tlpend   <= '0;
            pl_tlpedb   <= '0;
            pl_dlpstart <= '0;
            pl_dlpend   <= '0;
            framing_err <= 1'b0;
        end else if (!valid_in) begin
            data_out    <= '0;
            pl_valid    <= '0;
            pl_tlpstart <= '0;
            pl_tlpend   <= '0;
            pl_tlpedb   <= '0;
            pl_dlpstart <= '0;
            pl_dlpend   <= '0;
            framing_err <= 1'b0;
        end else if (in_os_s) begin
            os_blk_r    <= 1'b1;
            data_out    <= data_in;
            pl_valid    <= '0;
            pl_tlpstart <= '0;
            pl_tlpend   <= '0;
            pl_tlpedb   <= '0;
            pl_dlpstart <= '0;
            pl_dlpend   <= '0;
            framing_err <= os_abort_s;
            if (os_abort_s) begin
                state_r <= ST_ERR;
                cnt_r   <= '0;
                len_r   <= '0;
            end
        end else begin
            os_blk_r    <= 1'b0;
            state_r     <= g_lane[LANES-1].st_out_s;
            cnt_r       <= g_lane[LANES-1].cnt_out_s;
            len_r       <= g_lane[LANES-1].len_out_s;
            data_out    <= data_in;
            pl_valid    <= nx_valid_s;
            pl_tlpstart <= nx_tlpstart_s;
            pl_tlpend   <= nx_tlpend_s;
            pl_tlpedb   <= nx_tlpedb_s;
            pl_dlpstart <= nx_dlpstart_s;
            pl_dlpend   <= nx_dlpend_s;
            framing_err <= |err_s;
        end
    end

endmodule

// File: tb/tb_gen3_framing_parser.sv
// Randomized bench for gen3_framing_parser against a packet-position reference
// model, preceded by directed framing scenarios.
module tb_gen3_framing_parser;

    localparam int         LANES = 16;
    localparam logic [1:0] SH_D  = 2'b10;
    localparam logic [1:0] SH_O  = 2'b01;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [8*LANES-1:0] data_in = '0;
    logic               valid_in = 1'b0;
    logic               block_start = 1'b0;
    logic [1:0]         sync_hdr = SH_D;
    logic [4:0]         active_lanes = 5'd4;
    logic [8*LANES-1:0] data_out;
    logic [LANES-1:0]   pl_valid, pl_tlpstart, pl_tlpend, pl_tlpedb, pl_dlpstart, pl_dlpend;
    logic               framing_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: packet kind (0 idle, 1 TLP, 2 DLLP, 3 EDB) and byte position in it
    int  m_kind = 0, m_pos = 0, m_total = 0, m_len_lo = 0;
    bit  m_hold = 1'b0, m_os = 1'b0;
    logic [15:0]  e_valid, e_ts, e_te, e_edb, e_ds, e_de;
    logic         e_err;
    logic [127:0] e_data;
    logic [7:0]   byte_q[$];

    gen3_framing_parser #(.LANES(LANES), .CNT_W(13)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .block_start(block_start), .sync_hdr(sync_hdr), .active_lanes(active_lanes),
        .data_out(data_out), .pl_valid(pl_valid), .pl_tlpstart(pl_tlpstart),
        .pl_tlpend(pl_tlpend), .pl_tlpedb(pl_tlpedb), .pl_dlpstart(pl_dlpstart),
        .pl_dlpend(pl_dlpend), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input int b, input logic [7:0] bt);
        int len;
        if (m_kind == 0) begin
            if (bt[3:0] == 4'hF) begin
                m_kind = 1; m_pos = 1; m_len_lo = int'(bt[7:4]);
                e_valid[b] = 1'b1; e_ts[b] = 1'b1;
            end else if (bt == 8'hF0) begin
                m_kind = 2; m_pos = 1; m_total = 8;
                e_valid[b] = 1'b1; e_ds[b] = 1'b1;
            end else if (bt == 8'hC0) begin
                m_kind = 3; m_pos = 1; m_total = 4;
                e_valid[b] = 1'b1; e_edb[b] = 1'b1;
            end else if (bt != 8'h00) begin
                e_err = 1'b1; m_hold = 1'b1;
            end
        end else if (m_kind == 1 && m_pos == 1) begin
            len = int'(bt[6:0]) * 16 + m_len_lo;
            if (len < 5) begin
                e_err = 1'b1; m_hold = 1'b1; m_kind = 0;
            end else begin
                m_total = 4 * len; m_pos = 2; e_valid[b] = 1'b1;
            end
        end else if (m_kind == 3 && bt != 8'hC0) begin
            e_err = 1'b1; m_hold = 1'b1; m_kind = 0;
        end else begin
            e_valid[b] = 1'b1;
            if (m_kind == 3) e_edb[b] = 1'b1;
            if (m_pos == m_total - 1) begin
                if (m_kind == 1) e_te[b] = 1'b1;
                if (m_kind == 2) e_de[b] = 1'b1;
                m_kind = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit bs, input logic [1:0] sh,
                              input int al, input logic [127:0] d);
        {e_valid, e_ts, e_te, e_edb, e_ds, e_de} = '0;
        e_err  = 1'b0;
        e_data = '0;
        if (!r) begin
            m_kind = 0; m_pos = 0; m_total = 0; m_len_lo = 0; m_hold = 1'b0; m_os = 1'b0;
        end else if (v) begin
            e_data = d;
            if (bs && sh == SH_D) begin
                m_os = 1'b0;
                if (m_hold) begin m_hold = 1'b0; m_kind = 0; end
            end else if (bs) begin
                m_os = 1'b1;
                if (m_kind != 0 && !m_hold) begin e_err = 1'b1; m_hold = 1'b1; m_kind = 0; end
            end
            if (!m_os) begin
                for (int b = 0; b < al; b++) begin
                    if (!m_hold) model_byte(b, d[8*b +: 8]);
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input bit bs, input logic [1:0] sh,
                       input int al, input logic [127:0] d);
        rst = r; valid_in = v; block_start = bs; sync_hdr = sh;
        active_lanes = 5'(al); data_in = d;
        model_step(r, v, bs, sh, al, d);
        @(posedge clk);
        #1;
        check_val("data_out", data_out, e_data);
        check_val("pl_valid", pl_valid, e_valid);
        check_val("pl_tlpstart", pl_tlpstart, e_ts);
        check_val("pl_tlpend", pl_tlpend, e_te);
        check_val("pl_tlpedb", pl_tlpedb, e_edb);
        check_val("pl_dlpstart", pl_dlpstart, e_ds);
        check_val("pl_dlpend", pl_dlpend, e_de);
        check_val("framing_err", framing_err, e_err);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] lanes4(input logic [7:0] b0, b1, b2, b3);
        logic [127:0] w;
        w = rnd128();
        w[31:0] = {b3, b2, b1, b0};
        return w;
    endfunction

    task automatic push_stp(input int len);
        logic [10:0] l;
        l = 11'(len);
        byte_q.push_back({l[3:0], 4'hF});
        byte_q.push_back({1'($urandom), l[10:4]});
        for (int k = 0; k < 4 * len - 2; k++) byte_q.push_back(8'($urandom));
    endtask

    task automatic gen_pkt();
        int k;
        k = $urandom_range(0, 99);
        if (k < 40) push_stp($urandom_range(5, 24));
        else if (k < 60) begin
            byte_q.push_back(8'hF0);
            for (int j = 0; j < 7; j++) byte_q.push_back(8'($urandom));
        end else if (k < 72) begin
            for (int j = 0; j < 4; j++) byte_q.push_back(8'hC0);
        end else if (k < 90) byte_q.push_back(8'h00);
        else if (k < 94) byte_q.push_back(8'h5A);
        else if (k < 97) begin
            byte_q.push_back({4'($urandom_range(0, 4)), 4'hF});
            byte_q.push_back({1'($urandom), 7'h00});
        end else begin
            byte_q.push_back(8'hC0); byte_q.push_back(8'hC0); byte_q.push_back(8'h3C);
        end
    endtask

    task automatic run_q(input int al, input int n, input bit bs0);
        logic [127:0] d;
        for (int c = 0; c < n; c++) begin
            d = rnd128();
            for (int b = 0; b < al; b++) begin
                if (byte_q.size() == 0) byte_q.push_back(8'h00);
                d[8*b +: 8] = byte_q.pop_front();
            end
            cyc(1'b1, 1'b1, bs0 && (c == 0), SH_D, al, d);
        end
    endtask

    initial begin
        int al_tab[5] = '{1, 2, 4, 8, 16};
        int al;
        bit r, v, bs;
        logic [1:0]   sh;
        logic [127:0] d;

        cyc(1'b0, 1'b1, 1'b0, SH_D, 4, rnd128());
        cyc(1'b0, 1'b1, 1'b0, SH_D, 4, rnd128());

        // STP len=5 over five cycles
        cyc(1'b1, 1'b1, 1'b1, SH_D, 4, lanes4(8'h5F, 8'h00, 8'h12, 8'h34));
        check_val("stp5_start", pl_tlpstart, 16'h0001);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
        check_val("stp5_end", pl_tlpend, 16'h0008);

        // SDP from byte 2, then idles
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h00, 8'h00, 8'hF0, 8'hAC));
        check_val("sdp_start", pl_dlpstart, 16'h0004);
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h11, 8'h22, 8'h33, 8'h44));
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h55, 8'h66, 8'h00, 8'h00));
        check_val("sdp_end", pl_dlpend, 16'h0002);
        check_val("idl_valid", pl_valid, 16'h0003);

        // TLP ending at byte 1 followed by EDB, then a broken EDB
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h00, 8'h00, 8'h5F, 8'h00));
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)));
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h77, 8'h88, 8'hC0, 8'hC0));
        check_val("tlp_end_b1", pl_tlpend, 16'h0002);
        check_val("edb_first", pl_tlpedb, 16'h000C);
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'hC0, 8'hC0, 8'hC0, 8'hC0));
        check_val("edb_second", pl_tlpedb, 16'h000F);
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'hC1, 8'h00, 8'h00, 8'h00));
        check_val("edb_bad", framing_err, 1'b1);

        // Recovery straight into a too-short STP, hold, then recovery at byte 0
        cyc(1'b1, 1'b1, 1'b1, SH_D, 4, lanes4(8'h3F, 8'h00, 8'h00, 8'h00));
        check_val("stp3_err", framing_err, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h5F, 8'h00, 8'h00, 8'h00));
        check_val("err_hold", pl_valid, 16'h0000);
        cyc(1'b1, 1'b1, 1'b1, SH_D, 4, lanes4(8'h5F, 8'h00, 8'h01, 8'h02));
        check_val("err_recover", pl_tlpstart, 16'h0001);

        // Ordered-set block mid-TLP, then in TOKEN state
        cyc(1'b1, 1'b1, 1'b1, SH_O, 4, rnd128());
        check_val("os_mid_tlp", framing_err, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, SH_D, 4, lanes4(8'h5F, 8'h00, 8'h00, 8'h00));
        cyc(1'b1, 1'b1, 1'b1, SH_D, 4, lanes4(8'h00, 8'h00, 8'h00, 8'h00));
        cyc(1'b1, 1'b1, 1'b1, SH_O, 4, lanes4(8'hF0, 8'h00, 8'h00, 8'h00));
        check_val("os_token", framing_err, 1'b0);
        check_val("os_markers", pl_dlpstart, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, SH_D, 4, rnd128());
        cyc(1'b1, 1'b1, 1'b1, SH_D, 4, lanes4(8'h00, 8'h00, 8'h00, 8'h00));

        // Reset mid-TLP and a fresh STP at several widths
        foreach (al_tab[j]) begin
            if (al_tab[j] == 1 || al_tab[j] == 4 || al_tab[j] == 16) begin
                byte_q.delete();
                push_stp(20);
                run_q(al_tab[j], 2, 1'b1);
                cyc(1'b0, 1'b1, 1'b0, SH_D, al_tab[j], rnd128());
                check_val("rst_mid_tlp", pl_valid, 16'h0000);
                byte_q.delete();
                push_stp(5);
                run_q(al_tab[j], 1, 1'b0);
                check_val("post_rst_stp", pl_tlpstart, 16'h0001);
                run_q(al_tab[j], 20 / al_tab[j] + 1, 1'b0);
            end
        end

        // Randomized stream with block boundaries, stalls and resets
        byte_q.delete();
        al = 4;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 399) != 0);
            v  = ($urandom_range(0, 14) != 0);
            bs = ($urandom_range(0, 9) == 0);
            sh = ($urandom_range(0, 4) == 0) ? SH_O : SH_D;
            if ($urandom_range(0, 49) == 0) al = al_tab[$urandom_range(0, 4)];
            if (!r || (v && bs && sh == SH_O)) byte_q.delete();
            d = rnd128();
            if (v) begin
                for (int b = 0; b < al; b++) begin
                    if (byte_q.size() == 0) gen_pkt();
                    d[8*b +: 8] = byte_q.pop_front();
                end
            end
            cyc(r, v, bs, sh, al, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
